mil_tx_sequencer: RTL and testbench
===================================

MIL_TX_SEQUENCER -- requirements
Module: mil_tx_sequencer

Interface
REQ-001 Parameter: HALF_BIT, default 8, clocks per Manchester half-bit (0.5 us at 16 MHz clk); legal range 2..255.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle message request; sampled only in IDLE.
REQ-006 wcnt  input  2  words in message minus one (0 -> 1 word, 3 -> 4 words); sampled with start.
REQ-007 first_cmd  input  1  sync of word 0: 1 = command/status sync, 0 = data sync; sampled with start.
REQ-008 adr  output  2  word select driven to the upstream 4:1 16-bit word mux.
REQ-009 din  input  16  selected word returned by the mux (combinational function of adr).
REQ-010 txp  output  1  Manchester positive line to transceiver.
REQ-011 txn  output  1  Manchester negative line; complement of txp while transmitting.
REQ-012 busy  output  1  high from the cycle after start acceptance until the end of the last half-bit.
REQ-013 done  output  1  one-cycle pulse at message end.

Function
REQ-014 States: IDLE, SYNC, DATA, PAR; half-bit counter (0..HALF_BIT-1), half-bit index, bit index (15..0), word index (0..3).
REQ-015 IDLE: adr = 0, txp = txn = 0 (line inhibited), busy = 0.
REQ-016 start in IDLE: latch wcnt and first_cmd, load 17-bit shift register with {din, ~^din} (odd parity), set adr <= 1, go to SYNC; busy = 1 next cycle.
REQ-017 Each half-bit lasts exactly HALF_BIT clocks; a word lasts exactly 40*HALF_BIT clocks.
REQ-018 SYNC: 6 half-bits; command sync = txp high 3 half-bits then low 3; data sync = low 3 then high 3.
REQ-019 Sync of word 0 follows first_cmd; words 1..3 always use data sync.
REQ-020 DATA: 16 bits, MSB (bit 15) first; bit 1 = txp high then low, bit 0 = txp low then high.
REQ-021 PAR: one Manchester bit equal to the latched odd-parity bit (16 data bits plus parity contain an odd number of ones).
REQ-022 On the last clock of PAR with words remaining: load shift register from din, set adr <= adr+1 (mod 4), enter SYNC; no idle clocks between words.
REQ-023 The adr value for word k+1 is stable for at least 40*HALF_BIT-1 clocks before it is sampled.
REQ-024 On the last clock of PAR of the final word: go to IDLE, adr <= 0, txp/txn <= 0, busy <= 0, done <= 1 for one cycle.
REQ-025 start while busy is ignored; wcnt/first_cmd changes while busy have no effect.
REQ-026 start coincident with the done cycle is accepted (state is IDLE).
REQ-027 txp and txn are registered outputs; txn = ~txp whenever busy = 1.

Reset
REQ-028 rst forces next cycle: state IDLE, counters 0, adr = 0, txp = txn = 0, busy = 0, done = 0.
REQ-029 rst mid-word aborts the message with no completion of the current bit and no done pulse.
REQ-030 rst has priority over start in the same cycle.

Verification
REQ-031 HALF_BIT=8, mux word0 = 16'hA5F0, start, wcnt=0, first_cmd=1 -> txp: 24 clk high, 24 low, then 1010 0101 1111 0000 Manchester, parity 1 (eight ones); busy high 320 clk; done one pulse; adr returns 0.
REQ-032 Words 16'h0001,16'h0002,16'h0003,16'hFFFF, wcnt=3, first_cmd=0 -> four contiguous 320-clk words, all data sync, parity bits 0,0,1,1; adr sequence 0,1,2,3,0; busy 1280 clk.
REQ-033 Word 16'h0000, first_cmd=0 -> data sync (low 24, high 24), 16 "low-then-high" bits, parity 1; txn = ~txp throughout.
REQ-034 Second start pulse at clock 100 of a 1-word message -> ignored; exactly one word, one done.
REQ-035 rst asserted at clock 150 of a 2-word message -> next cycle txp = txn = 0, busy = 0, adr = 0, no done; fresh start afterwards transmits correctly.
REQ-036 start asserted in the done cycle -> new message starts with no gap beyond one clock; adr reset to 0 and word 0 reloaded.

Source files
------------

// File: rtl/mil_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// mil_tx_sequencer_if
// Groups the message-request handshake, the word-mux connection and the
// Manchester line outputs of the MIL-STD-1553 style transmit sequencer.
//   start      single-cycle message request
//   wcnt[1:0]  words in message minus one
//   first_cmd  sync type of word 0 (1 = command/status, 0 = data)
//   adr[1:0]   word select to the upstream 4:1 word mux
//   din[15:0]  word returned by the mux (combinational in adr)
//   txp/txn    Manchester line pair to the transceiver
//   busy       message in progress
//   done       one-cycle end-of-message pulse
// master: the requesting side that also owns the word mux.
// slave : the sequencer.
// ---------------------------------------------------------------------------
interface mil_tx_sequencer_if;
    logic        start;
    logic [1:0]  wcnt;
    logic        first_cmd;
    logic [1:0]  adr;
    logic [15:0] din;
    logic        txp;
    logic        txn;
    logic        busy;
    logic        done;

    modport master (
        output start, wcnt, first_cmd, din,
        input  adr, txp, txn, busy, done
    );

    modport slave (
        input  start, wcnt, first_cmd, din,
        output adr, txp, txn, busy, done
    );
endinterface

// File: rtl/mil_tx_sequencer.sv
// ---------------------------------------------------------------------------
// mil_tx_sequencer
// Serialises a 1..4 word message as Manchester II words: 3-bit-time sync,
// 16 data bits MSB first, odd parity. Each word is 40 half-bits long and
// consecutive words are sent back to back.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   mil_tx_sequencer_if.slave (request, word mux, line outputs)
// Parameter:
//   HALF_BIT  clocks per Manchester half-bit (2..255)
// ---------------------------------------------------------------------------
module mil_tx_sequencer #(
    parameter int HALF_BIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mil_tx_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;

    localparam logic [7:0] HB_LAST = 8'(HALF_BIT - 1);

    state_t      r_state,    w_state_next;
    logic [7:0]  r_hcnt,     w_hcnt_next;      // clock within half-bit
    logic [2:0]  r_half,     w_half_next;      // half-bit within SYNC (0..5) or bit (0..1)
    logic [3:0]  r_bit,      w_bit_next;       // data bit index, 15 down to 0
    logic [1:0]  r_word,     w_word_next;
    logic [1:0]  r_wcnt,     w_wcnt_next;
    logic        r_cmd_sync, w_cmd_sync_next;  // sync type of the word in flight
    logic [16:0] r_shift,    w_shift_next;     // bit 16 is always the bit on the line
    logic [1:0]  r_adr,      w_adr_next;
    logic        r_txp,      w_txp_next;
    logic        r_txn,      w_txn_next;
    logic        r_busy,     w_busy_next;
    logic        r_done,     w_done_next;

    logic        w_half_end;
    logic [16:0] w_load_word;

    assign w_half_end  = (r_hcnt == HB_LAST);
    // Parity bit appended below the data so that, after 16 left shifts,
    // it lands in bit 16 ready for the PAR bit time.
    assign w_load_word = {bus.din, ~^bus.din};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hcnt     <= '0;
            r_half     <= '0;
            r_bit      <= '0;
            r_word     <= '0;
            r_wcnt     <= '0;
            r_cmd_sync <= 1'b0;
            r_shift    <= '0;
            r_adr      <= '0;
            r_txp      <= 1'b0;
            r_txn      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hcnt     <= w_hcnt_next;
            r_half     <= w_half_next;
            r_bit      <= w_bit_next;
            r_word     <= w_word_next;
            r_wcnt     <= w_wcnt_next;
            r_cmd_sync <= w_cmd_sync_next;
            r_shift    <= w_shift_next;
            r_adr      <= w_adr_next;
            r_txp      <= w_txp_next;
            r_txn      <= w_txn_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next    = r_state;
        w_hcnt_next     = r_hcnt;
        w_half_next     = r_half;
        w_bit_next      = r_bit;
        w_word_next     = r_word;
        w_wcnt_next     = r_wcnt;
        w_cmd_sync_next = r_cmd_sync;
        w_shift_next    = r_shift;
        w_adr_next      = r_adr;

        if (r_state == S_IDLE) begin
            if (bus.start) begin
                w_state_next    = S_SYNC;
                w_hcnt_next     = '0;
                w_half_next     = '0;
                w_bit_next      = 4'd15;
                w_word_next     = '0;
                w_wcnt_next     = bus.wcnt;
                w_cmd_sync_next = bus.first_cmd;
                w_shift_next    = w_load_word;
                w_adr_next      = 2'd1;
            end
        end else if (!w_half_end) begin
            w_hcnt_next = r_hcnt + 8'd1;
        end else begin
            w_hcnt_next = '0;
            case (r_state)
                S_SYNC: begin
                    if (r_half == 3'd5) begin
                        w_state_next = S_DATA;
                        w_half_next  = '0;
                        w_bit_next   = 4'd15;
                    end else begin
                        w_half_next = r_half + 3'd1;
                    end
                end
                S_DATA: begin
                    if (r_half == 3'd0) begin
                        w_half_next = 3'd1;
                    end else begin
                        w_half_next  = '0;
                        w_shift_next = {r_shift[15:0], 1'b0};
                        if (r_bit == 4'd0) begin
                            w_state_next = S_PAR;
                        end else begin
                            w_bit_next = r_bit - 4'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (r_half == 3'd0) begin
                        w_half_next = 3'd1;
                    end else if (r_word == r_wcnt) begin
                        w_state_next = S_IDLE;
                        w_half_next  = '0;
                        w_adr_next   = '0;
                    end else begin
                        // Next word starts on the very next clock; its mux
                        // word has been selected since this word began.
                        w_state_next    = S_SYNC;
                        w_half_next     = '0;
                        w_word_next     = r_word + 2'd1;
                        w_cmd_sync_next = 1'b0;
                        w_shift_next    = w_load_word;
                        w_adr_next      = r_adr + 2'd1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output logic: evaluated on the next-state values so that the line
    // outputs are registered yet aligned with the half-bit being entered.
    always_comb begin
        w_busy_next = (w_state_next != S_IDLE);
        w_done_next = (r_state == S_PAR) && (w_state_next == S_IDLE);
        case (w_state_next)
            S_IDLE:  w_txp_next = 1'b0;
            S_SYNC:  w_txp_next = w_cmd_sync_next ? (w_half_next < 3'd3)
                                                  : (w_half_next >= 3'd3);
            // Bit value in the first half, its complement in the second.
            default: w_txp_next = w_shift_next[16] ^ w_half_next[0];
        endcase
        w_txn_next = w_busy_next & ~w_txp_next;
    end

    assign bus.adr  = r_adr;
    assign bus.txp  = r_txp;
    assign bus.txn  = r_txn;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_mil_tx_sequencer.sv
module tb_mil_tx_sequencer;

    localparam int HB = 8;

    logic        clk;
    logic        rst;
    logic [15:0] words [4];
    logic [5:0]  expq [$];   // {busy, done, txp, txn, adr}
    int          vectors;
    int          miscompares;

    mil_tx_sequencer_if bus ();

    assign bus.din = words[bus.adr];

    mil_tx_sequencer #(.HALF_BIT(HB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) expq.push_back(6'b000000);
    endtask

    // Expected per-clock outputs for a whole message, built from the
    // Manchester definition of sync, data and odd parity.
    task automatic push_msg(input logic [1:0] wc, input logic fc);
        logic [15:0] w;
        logic        par;
        logic        lv;
        logic [1:0]  a;
        int          b;
        for (int k = 0; k <= int'(wc); k++) begin
            w   = words[k];
            par = (($countones(w) % 2) == 0) ? 1'b1 : 1'b0;
            a   = 2'((k + 1) % 4);
            for (int h = 0; h < 40; h++) begin
                if (h < 6) begin
                    if (k == 0 && fc) lv = (h < 3);
                    else              lv = (h >= 3);
                end else if (h < 38) begin
                    b  = 15 - (h - 6) / 2;
                    lv = (((h - 6) % 2) == 0) ? w[b] : ~w[b];
                end else begin
                    lv = (h == 38) ? par : ~par;
                end
                for (int c = 0; c < HB; c++) expq.push_back({1'b1, 1'b0, lv, ~lv, a});
            end
        end
        expq.push_back(6'b010000);
    endtask

    task automatic check_n(input int n, input string tag);
        logic [5:0] obs;
        logic [5:0] e;
        for (int i = 0; i < n; i++) begin
            obs = {bus.busy, bus.done, bus.txp, bus.txn, bus.adr};
            e   = (expq.size() > 0) ? expq.pop_front() : 6'b111111;
            vectors++;
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s cyc%0d observed=%b expected=%b", tag, i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    // Issue a start at the current negedge; wcnt/first_cmd are scrambled
    // right after acceptance and must not matter.
    task automatic kick(input logic [1:0] wc, input logic fc, input logic pre_idle);
        if (pre_idle) push_idle(1);
        push_msg(wc, fc);
        bus.start     = 1'b1;
        bus.wcnt      = wc;
        bus.first_cmd = fc;
        check_n(1, "accept");
        bus.start     = 1'b0;
        bus.wcnt      = ~wc;
        bus.first_cmd = ~fc;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.wcnt      = 2'd0;
        bus.first_cmd = 1'b0;
        for (int i = 0; i < 4; i++) words[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_idle(4);
        check_n(4, "reset");
        $display("txn reset: idle outputs checked, miscompares=%0d", miscompares);

        // Single command-sync word
        words[0] = 16'hA5F0;
        kick(2'd0, 1'b1, 1'b1);
        check_n(321, "w_a5f0");
        $display("txn 1 word A5F0 cmd sync, miscompares=%0d", miscompares);

        // Four contiguous data-sync words
        words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003; words[3] = 16'hFFFF;
        kick(2'd3, 1'b0, 1'b1);
        check_n(1281, "w4");
        $display("txn 4 words data sync, miscompares=%0d", miscompares);

        // All-zero word with data sync
        words[0] = 16'h0000;
        kick(2'd0, 1'b0, 1'b1);
        check_n(321, "w_0000");
        $display("txn 1 word 0000 data sync, miscompares=%0d", miscompares);

        // Start while busy is ignored
        words[0] = 16'h3C5A;
        kick(2'd0, 1'b1, 1'b1);
        check_n(100, "busy_start_pre");
        bus.start = 1'b1;
        bus.wcnt  = 2'd3;
        check_n(1, "busy_start_pulse");
        bus.start = 1'b0;
        check_n(220, "busy_start_post");
        $display("txn start while busy ignored, miscompares=%0d", miscompares);

        // Reset mid-message aborts without done
        words[0] = 16'h1234; words[1] = 16'h8001;
        kick(2'd1, 1'b1, 1'b1);
        check_n(150, "abort_pre");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        push_idle(3);
        check_n(3, "abort_idle");
        // Reset wins over a coincident start
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        push_idle(3);
        check_n(3, "rst_prio");
        kick(2'd0, 1'b0, 1'b1);
        check_n(321, "after_abort");
        $display("txn reset abort then fresh word, miscompares=%0d", miscompares);

        // Start in the done cycle: back-to-back messages
        words[0] = 16'hC001;
        kick(2'd0, 1'b1, 1'b1);
        check_n(320, "b2b_first");
        words[0] = 16'h7E81; words[1] = 16'h0F0F;
        kick(2'd1, 1'b0, 1'b0);
        check_n(641, "b2b_second");
        push_idle(2);
        check_n(2, "b2b_idle");
        $display("txn start in done cycle, miscompares=%0d", miscompares);

        vectors++;
        assert (expq.size() === 0) else begin
            miscompares++;
            $error("FAIL queue_drained observed=%0d expected=0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
